// File: rtl/ni_initiator.sv
// NoC initiator endpoint: serializes request packets from a local FIFO into
// head/body/tail flits and reassembles the single outstanding response.
module ni_initiator #(
  parameter int FLIT_W     = 16,
  parameter int BODY_FLITS = 3,
  parameter int PKT_W      = FLIT_W * (BODY_FLITS + 2)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [PKT_W-1:0]  req_fifo_dout,
  input  logic              req_fifo_empty,
  output logic              req_fifo_rreq,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_en,
  input  logic              dst_ready,
  input  logic [FLIT_W-1:0] resp_flit_in,
  input  logic              resp_valid,
  output logic [PKT_W-1:0]  resp_fifo_din,
  output logic              resp_fifo_wreq,
  input  logic              resp_fifo_full,
  output logic              busy,
  output logic              rx_overrun
);

  localparam int NFLITS = BODY_FLITS + 2;
  localparam int CNT_W  = $clog2(NFLITS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NFLITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [2:0] {
    TX_IDLE     = 3'd0,
    TX_FETCH    = 3'd1,
    TX_LOAD     = 3'd2,
    TX_WAIT_RDY = 3'd3,
    TX_SEND     = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_CAPTURE = 2'd1,
    RX_WRITE   = 2'd2
  } rx_state_t;

  // Slot 0 (head) occupies the MSBs of the flat packet.
  function automatic logic [FLIT_W-1:0] pick_flit(input logic [PKT_W-1:0] pkt,
                                                  input logic [CNT_W-1:0] idx);
    logic [FLIT_W-1:0] f;
    f = {FLIT_W{1'b0}};
    for (int i = 0; i < NFLITS; i++) begin
      if (idx == CNT_W'(i)) begin
        f = pkt[(NFLITS-1-i)*FLIT_W +: FLIT_W];
      end
    end
    return f;
  endfunction

  tx_state_t         tx_state_r, tx_next_s;
  rx_state_t         rx_state_r, rx_next_s;
  logic [CNT_W-1:0]  beat_r, beat_next_s;
  logic [CNT_W-1:0]  rx_cnt_r, cnt_next_s;
  logic [PKT_W-1:0]  tx_buf_r;
  logic [PKT_W-1:0]  rx_buf_r;
  logic              outstanding_r, outst_next_s;
  logic              tail_s, store_s, wreq_s;
  logic              rreq_r, flit_en_r, busy_r, overrun_r;
  logic [FLIT_W-1:0] flit_out_r;

  // TX next-state: fetch, load, wait for ready, then a gapless burst
  always_comb begin
    tx_next_s   = tx_state_r;
    beat_next_s = CNT_ZERO;
    tail_s      = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (!req_fifo_empty && !outstanding_r) tx_next_s = TX_FETCH;
        else tx_next_s = TX_IDLE;
      end
      TX_FETCH: tx_next_s = TX_LOAD;
      TX_LOAD:  tx_next_s = TX_WAIT_RDY;
      TX_WAIT_RDY: begin
        if (dst_ready) tx_next_s = TX_SEND;
        else tx_next_s = TX_WAIT_RDY;
      end
      TX_SEND: begin
        if (beat_r == LAST_BEAT) begin
          tx_next_s = TX_IDLE;
          tail_s    = 1'b1;
        end else begin
          beat_next_s = beat_r + CNT_ONE;
        end
      end
      default: tx_next_s = TX_IDLE;
    endcase
  end

  // Outstanding flag: a tail beat in the same cycle as a response write wins
  always_comb begin
    if (tail_s) outst_next_s = 1'b1;
    else if (wreq_s) outst_next_s = 1'b0;
    else outst_next_s = outstanding_r;
  end

  // TX state, packet buffer and registered TX-side outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_r    <= TX_IDLE;
      beat_r        <= CNT_ZERO;
      tx_buf_r      <= {PKT_W{1'b0}};
      outstanding_r <= 1'b0;
      rreq_r        <= 1'b0;
      flit_en_r     <= 1'b0;
      flit_out_r    <= {FLIT_W{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      tx_state_r    <= tx_next_s;
      beat_r        <= beat_next_s;
      outstanding_r <= outst_next_s;
      if (tx_state_r == TX_LOAD) tx_buf_r <= req_fifo_dout;
      rreq_r        <= (tx_next_s == TX_FETCH);
      flit_en_r     <= (tx_next_s == TX_SEND);
      flit_out_r    <= (tx_next_s == TX_SEND) ? pick_flit(tx_buf_r, beat_next_s)
                                              : {FLIT_W{1'b0}};
      busy_r        <= (tx_next_s != TX_IDLE) | outst_next_s;
    end
  end

  // RX next-state: capture flits (gaps allowed) until the tail, then write out
  always_comb begin
    rx_next_s  = rx_state_r;
    cnt_next_s = rx_cnt_r;
    store_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE, RX_CAPTURE: begin
        if (resp_valid) begin
          store_s = 1'b1;
          if (rx_cnt_r == LAST_BEAT) begin
            rx_next_s  = RX_WRITE;
            cnt_next_s = CNT_ZERO;
          end else begin
            rx_next_s  = RX_CAPTURE;
            cnt_next_s = rx_cnt_r + CNT_ONE;
          end
        end else begin
          rx_next_s = rx_state_r;
        end
      end
      RX_WRITE: begin
        if (!resp_fifo_full) rx_next_s = RX_IDLE;
        else rx_next_s = RX_WRITE;
      end
      default: begin
        rx_next_s  = RX_IDLE;
        cnt_next_s = CNT_ZERO;
      end
    endcase
  end

  assign wreq_s = (rx_state_r == RX_WRITE) && !resp_fifo_full;

  // RX state, reassembly buffer and sticky overrun
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_buf_r   <= {PKT_W{1'b0}};
      overrun_r  <= 1'b0;
    end else begin
      rx_state_r <= rx_next_s;
      rx_cnt_r   <= cnt_next_s;
      if (store_s) begin
        for (int i = 0; i < NFLITS; i++) begin
          if (rx_cnt_r == CNT_W'(i)) rx_buf_r[(NFLITS-1-i)*FLIT_W +: FLIT_W] <= resp_flit_in;
        end
      end
      if ((rx_state_r == RX_WRITE) && resp_valid) overrun_r <= 1'b1;
    end
  end

  assign req_fifo_rreq  = rreq_r;
  assign flit_en        = flit_en_r;
  assign flit_out       = flit_out_r;
  assign busy           = busy_r;
  assign resp_fifo_din  = rx_buf_r;
  assign resp_fifo_wreq = wreq_s;
  assign rx_overrun     = overrun_r;

endmodule
